// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-counter and fetch-sequencing stage of the 8-bit core. It produces
//   the instruction-memory address each cycle, redirects on a taken BLQZ and
//   squashes the wrong-path fetch with bubbles. It also owns program start and
//   halt.
//
//   Parameters
//     PC_W         program-counter width (instruction memory is 2^PC_W words)
//     START_PC     PC loaded on reset and on every start pulse
//     FLUSH_CYCLES bubbles inserted after a taken branch (1..3)
//
//   Ports
//     clock        rising-edge clock
//     reset_n      asynchronous active-low reset
//     start        one-cycle pulse, honoured in IDLE or DONE only
//     stall        holds pc and fetch_valid (RUN only)
//     jump_flag    registered taken-branch flag from the execute ALU
//     jump_target  branch destination, used only when jump_flag=1
//     halt_req     decoded halt instruction reached execute
//     pc           instruction-memory fetch address
//     fetch_valid  instruction at pc is on the committed path
//     done         program finished; held until the next start
//     branch_count taken branches since last start, saturating at 255
module pc_fetch_sequencer #(
  parameter int unsigned          PC_W         = 10,
  parameter logic [PC_W-1:0]      START_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stall,
  input  logic            jump_flag,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            done,
  output logic [7:0]      branch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [1:0]        fcnt_q, fcnt_d;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; RUN priority is halt > jump > stall
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (halt_req)       state_d = DONE;
        else if (jump_flag) state_d = FLUSH;
      end
      FLUSH: if (fcnt_q == 2'd0) state_d = RUN;
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the flush counter
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          valid_d = 1'b1;
          done_d  = 1'b0;
          bcnt_d  = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else if (jump_flag) begin
          pc_d    = jump_target;
          valid_d = 1'b0;
          fcnt_d  = FLUSH_INIT;
          if (bcnt_q != 8'hFF) bcnt_d = bcnt_q + 8'd1;
        end else if (!stall) begin
          pc_d    = pc_q + PC_W'(1);
          valid_d = 1'b1;
        end
      end
      FLUSH: begin
        // Counter runs regardless of stall; leaving with pc unchanged
        // fetches the branch target itself.
        if (fcnt_q == 2'd0) valid_d = 1'b1;
        else begin
          valid_d = 1'b0;
          fcnt_d  = fcnt_q - 2'd1;
        end
      end
      DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (start) begin
          pc_d    = START_PC;
          valid_d = 1'b1;
          done_d  = 1'b0;
          bcnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = valid_q;
  assign done         = done_q;
  assign branch_count = bcnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. Three instances share stimulus:
//   u0: PC_W=10, START_PC=0,  FLUSH_CYCLES=1 (main behaviour)
//   u1: PC_W=10, START_PC=0,  FLUSH_CYCLES=3 (bubble count)
//   u2: PC_W=4,  START_PC=14, FLUSH_CYCLES=1 (pc wrap)
// Each phase resets all instances and checks only the instance it targets.
module tb_pc_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       jump_flag = 1'b0;
  logic       halt_req = 1'b0;
  logic [9:0] jump_target = '0;

  logic [9:0] pc0, pc1;
  logic [3:0] pc2;
  logic       fv0, fv1, fv2;
  logic       dn0, dn1, dn2;
  logic [7:0] bc0, bc1, bc2;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clock = ~clock;

  pc_fetch_sequencer #(.PC_W(10), .START_PC(10'd0), .FLUSH_CYCLES(1)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .jump_flag(jump_flag), .jump_target(jump_target), .halt_req(halt_req),
    .pc(pc0), .fetch_valid(fv0), .done(dn0), .branch_count(bc0));

  pc_fetch_sequencer #(.PC_W(10), .START_PC(10'd0), .FLUSH_CYCLES(3)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .jump_flag(jump_flag), .jump_target(jump_target), .halt_req(halt_req),
    .pc(pc1), .fetch_valid(fv1), .done(dn1), .branch_count(bc1));

  pc_fetch_sequencer #(.PC_W(4), .START_PC(4'd14), .FLUSH_CYCLES(1)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .jump_flag(jump_flag), .jump_target(jump_target[3:0]), .halt_req(halt_req),
    .pc(pc2), .fetch_valid(fv2), .done(dn2), .branch_count(bc2));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stall = 1'b0; jump_flag = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // ---------------- u0: main behaviour ----------------
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_pc", 32'(pc0), 0);
    check("rst_fv", 32'(fv0), 0);
    check("rst_done", 32'(dn0), 0);
    check("rst_bc", 32'(bc0), 0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_pc", 32'(pc0), 0);
    check("start_fv", 32'(fv0), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("seq_pc", 32'(pc0), 32'(i));
      check("seq_fv", 32'(fv0), 1);
    end
    check("seq_done", 32'(dn0), 0);

    // Taken branch at pc=5 -> 40
    jump_flag = 1'b1; jump_target = 10'd40; tick(); clear_inputs();
    check("br_pc", 32'(pc0), 40);
    check("br_fv_bubble", 32'(fv0), 0);
    check("br_bc", 32'(bc0), 1);

    // Squashed jump/halt/start during FLUSH are ignored
    jump_flag = 1'b1; jump_target = 10'd7; halt_req = 1'b1; start = 1'b1;
    tick(); clear_inputs();
    check("flush_ign_pc", 32'(pc0), 40);
    check("flush_ign_fv", 32'(fv0), 1);
    check("flush_ign_done", 32'(dn0), 0);
    check("flush_ign_bc", 32'(bc0), 1);

    // start in RUN has no effect
    start = 1'b1; tick(); clear_inputs();
    check("run_start_pc", 32'(pc0), 41);

    // jump + stall: jump taken
    jump_flag = 1'b1; stall = 1'b1; jump_target = 10'd100; tick(); clear_inputs();
    check("js_pc", 32'(pc0), 100);
    check("js_fv", 32'(fv0), 0);
    check("js_bc", 32'(bc0), 2);
    tick();
    check("js_tgt_fv", 32'(fv0), 1);

    // stall holds
    stall = 1'b1; tick();
    check("stall_pc", 32'(pc0), 100);
    check("stall_fv", 32'(fv0), 1);
    stall = 1'b0; tick();
    check("unstall_pc", 32'(pc0), 101);

    // get to pc=12 then halt+jump together
    jump_flag = 1'b1; jump_target = 10'd12; tick(); clear_inputs();
    tick();
    check("pc12", 32'(pc0), 12);
    check("bc3", 32'(bc0), 3);
    halt_req = 1'b1; jump_flag = 1'b1; jump_target = 10'd3; tick(); clear_inputs();
    check("halt_pc", 32'(pc0), 12);
    check("halt_done", 32'(dn0), 1);
    check("halt_fv", 32'(fv0), 0);
    check("halt_bc", 32'(bc0), 3);
    tick();
    check("done_hold_pc", 32'(pc0), 12);
    check("done_hold", 32'(dn0), 1);

    // restart from DONE
    start = 1'b1; tick(); clear_inputs();
    check("restart_pc", 32'(pc0), 0);
    check("restart_done", 32'(dn0), 0);
    check("restart_bc", 32'(bc0), 0);
    check("restart_fv", 32'(fv0), 1);

    // jump_target equal to pc still flushes and counts
    jump_flag = 1'b1; jump_target = 10'd0; tick(); clear_inputs();
    check("self_pc", 32'(pc0), 0);
    check("self_fv", 32'(fv0), 0);
    check("self_bc", 32'(bc0), 1);
    tick();
    check("self_tgt_fv", 32'(fv0), 1);

    // saturation: 259 more branches (260 total)
    for (int i = 0; i < 259; i++) begin
      jump_flag = 1'b1; jump_target = 10'd20; tick();
      jump_flag = 1'b0; tick();
      if (i == 253) check("bc_255", 32'(bc0), 255);
    end
    check("bc_sat", 32'(bc0), 255);

    // async reset mid-FLUSH
    jump_flag = 1'b1; jump_target = 10'd50; tick(); clear_inputs();
    check("pre_rst_pc", 32'(pc0), 50);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc0), 0);
    check("arst_fv", 32'(fv0), 0);
    check("arst_bc", 32'(bc0), 0);
    check("arst_done", 32'(dn0), 0);
    reset_n = 1'b1;
    tick(); tick();
    check("idle_pc", 32'(pc0), 0);
    check("idle_fv", 32'(fv0), 0);

    // ---------------- u1: FLUSH_CYCLES=3 ----------------
    do_reset();
    start = 1'b1; tick(); clear_inputs();
    check("f3_start_pc", 32'(pc1), 0);
    jump_flag = 1'b1; jump_target = 10'd40; tick(); clear_inputs();
    stall = 1'b1;
    check("f3_b1_pc", 32'(pc1), 40);
    check("f3_b1_fv", 32'(fv1), 0);
    tick();
    check("f3_b2_fv", 32'(fv1), 0);
    tick();
    check("f3_b3_fv", 32'(fv1), 0);
    stall = 1'b0;
    tick();
    check("f3_tgt_fv", 32'(fv1), 1);
    check("f3_tgt_pc", 32'(pc1), 40);
    check("f3_bc", 32'(bc1), 1);

    // ---------------- u2: PC_W=4 wrap ----------------
    do_reset();
    check("w_rst_pc", 32'(pc2), 14);
    start = 1'b1; tick(); clear_inputs();
    check("w_pc14", 32'(pc2), 14);
    tick();
    check("w_pc15", 32'(pc2), 15);
    tick();
    check("w_pc0", 32'(pc2), 0);
    tick();
    check("w_pc1", 32'(pc2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
